bridge_sequencer: RTL and testbench

//  Owns the single Avalon bridge into SDRAM and shares it between two requesters: the SD-card

---
 rtl/mp3_bridge_pkg.sv | 17 +
 rtl/sample_fifo.sv | 58 +++++
 rtl/bridge_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_bridge_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_bridge_pkg.sv
// Shared types and constants for the SDRAM bridge sequencer.
package mp3_bridge_pkg;

  // Arbiter states: idle, loader write in flight, playback read in flight
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_W = 26;
  localparam int DEFAULT_DATA_W = 16;
  localparam int LOAD_ADDR_W    = 25;

  localparam logic [1:0] BYTE_EN_ALL = 2'b11;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding prefetched playback samples.
// The head word is presented combinationally and reads as zero when empty.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A pop on an empty FIFO is ignored even if a push lands in the same cycle;
  // a push on a full FIFO is only accepted when a pop frees the slot.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bridge_sequencer.sv
// Shares the single Avalon SDRAM bridge between the SD-card loader (writes)
// and the playback path (reads), prefetching samples into a small FIFO so the
// serializer only pops ready words.
module bridge_sequencer
  import mp3_bridge_pkg::*;
#(
  parameter int                  ADDR_W      = DEFAULT_ADDR_W,
  parameter int                  DATA_W      = DEFAULT_DATA_W,
  parameter int                  FIFO_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]   PLAY_END    = 26'h3FFFFFF,
  parameter int                  ACK_TIMEOUT = 255
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load_req,
  input  logic [LOAD_ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0]      load_data,
  input  logic                   load_done,
  output logic                   load_ack,
  input  logic                   play_en,
  input  logic                   sample_pop,
  output logic [DATA_W-1:0]      sample_data,
  output logic                   sample_valid,
  output logic                   underrun,
  output logic                   bus_error,
  output logic [ADDR_W-1:0]      bus_address,
  output logic [1:0]             bus_byte_enable,
  output logic                   bus_read,
  output logic                   bus_write,
  output logic [DATA_W-1:0]      bus_write_data,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_read_data
);

  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int                TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t             state;
  state_t             next_state;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   tmo_cnt_next;
  logic [ADDR_W-1:0]  play_addr;
  logic [ADDR_W-1:0]  play_addr_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [DATA_W-1:0]  wdata_next;
  logic               read_next;
  logic               write_next;
  logic               load_ack_next;
  logic               error_next;
  logic               ack_timeout;
  logic               can_grant;

  logic               fifo_push;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (bus_read_data),
    .pop       (sample_pop),
    .pop_data  (sample_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign sample_valid = (fifo_count != '0);
  assign ack_timeout  = (tmo_cnt == TMO_LAST);

  // The cycle in which load_ack is high is a forced idle cycle, giving the
  // loader time to advance load_req before the next grant is considered.
  assign can_grant = !load_ack;

  // Arbitration, transfer completion and next values for the registered bus outputs
  always_comb begin
    next_state     = state;
    tmo_cnt_next   = tmo_cnt;
    play_addr_next = play_addr;
    addr_next      = bus_address;
    wdata_next     = bus_write_data;
    read_next      = bus_read;
    write_next     = bus_write;
    load_ack_next  = 1'b0;
    error_next     = bus_error;
    fifo_push      = 1'b0;

    case (state)
      IDLE: begin
        tmo_cnt_next = '0;
        if (can_grant && load_req && !load_done) begin
          next_state = WRITE;
          addr_next  = ADDR_W'(load_addr);
          wdata_next = load_data;
          write_next = 1'b1;
        end else if (can_grant && play_en && load_done && !fifo_full) begin
          next_state = READ;
          addr_next  = play_addr;
          read_next  = 1'b1;
        end
      end

      WRITE: begin
        if (bus_ack) begin
          write_next    = 1'b0;
          load_ack_next = 1'b1;
          next_state    = IDLE;
        end else if (ack_timeout) begin
          write_next = 1'b0;
          error_next = 1'b1;
          next_state = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      READ: begin
        if (bus_ack) begin
          read_next      = 1'b0;
          fifo_push      = 1'b1;
          play_addr_next = (play_addr == PLAY_END) ? '0 : play_addr + 1'b1;
          next_state     = IDLE;
        end else if (ack_timeout) begin
          read_next  = 1'b0;
          error_next = 1'b1;
          next_state = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Arbiter state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Registered bus outputs, play address, timeout counter and loader handshake
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_cnt         <= '0;
      play_addr       <= '0;
      bus_address     <= '0;
      bus_write_data  <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_byte_enable <= 2'b00;
      load_ack        <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      tmo_cnt         <= tmo_cnt_next;
      play_addr       <= play_addr_next;
      bus_address     <= addr_next;
      bus_write_data  <= wdata_next;
      bus_read        <= read_next;
      bus_write       <= write_next;
      bus_byte_enable <= BYTE_EN_ALL;
      load_ack        <= load_ack_next;
      bus_error       <= error_next;
    end
  end

  // Sticky underrun flag: any pop seen while the FIFO holds nothing
  always_ff @(posedge Clk) begin
    if (Reset)                        underrun <= 1'b0;
    else if (sample_pop && fifo_empty) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_bridge_sequencer.sv
// Self-checking bench for bridge_sequencer: a bus responder model acks
// transfers, checks addresses/data and queues expected samples; the main
// sequence walks load, prefetch, wrap, underrun, timeout and priority/reset.
module tb_bridge_sequencer;

  localparam logic [25:0] TB_PLAY_END = 26'd11;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        load_req;
  logic [24:0] load_addr;
  logic [15:0] load_data;
  logic        load_done;
  logic        load_ack;
  logic        play_en;
  logic        sample_pop;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        underrun;
  logic        bus_error;
  logic [25:0] bus_address;
  logic [1:0]  bus_byte_enable;
  logic        bus_read;
  logic        bus_write;
  logic [15:0] bus_write_data;
  logic        bus_ack;
  logic [15:0] bus_read_data;

  bridge_sequencer #(
    .ADDR_W      (26),
    .DATA_W      (16),
    .FIFO_DEPTH  (8),
    .PLAY_END    (TB_PLAY_END),
    .ACK_TIMEOUT (4)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .load_req        (load_req),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done),
    .load_ack        (load_ack),
    .play_en         (play_en),
    .sample_pop      (sample_pop),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .underrun        (underrun),
    .bus_error       (bus_error),
    .bus_address     (bus_address),
    .bus_byte_enable (bus_byte_enable),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_write_data  (bus_write_data),
    .bus_ack         (bus_ack),
    .bus_read_data   (bus_read_data)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [25:0] addr;
    logic [15:0] data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] sample_q[$];
  wr_t         wr_q[$];
  wr_t         wr_exp;

  int          ack_lat = 1;
  logic        stall_active = 1'b0;
  logic [25:0] stall_addr = '0;
  int          strobe_cycles = 0;
  logic [25:0] exp_rd_addr = '0;
  logic [25:0] first_addr = '0;
  int          wrap_count = 0;
  logic        acked_last = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [24:0] addr, input logic [15:0] data,
                               input logic done, input logic en);
    load_req  = req;
    load_addr = addr;
    load_data = data;
    load_done = done;
    play_en   = en;
  endtask

  task automatic resetDut();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic popSample();
    checkOutput("pop_valid", 32'(sample_valid), 32'd1);
    if (sample_q.size() > 0) checkOutput("pop_data", 32'(sample_data), 32'(sample_q.pop_front()));
    else                     checkOutput("pop_sb_empty", 32'd1, 32'd0);
    sample_pop = 1'b1;
    tick();
    sample_pop = 1'b0;
  endtask

  // Bus slave model: acks after ack_lat strobe cycles, checks every transfer
  always @(negedge Clk) begin
    if (Reset) begin
      strobe_cycles = 0;
      bus_ack       = 1'b0;
      acked_last    = 1'b0;
      exp_rd_addr   = '0;
      sample_q.delete();
      wr_q.delete();
    end else begin
      if (acked_last) checkOutput("strobe_drop", 32'({bus_read, bus_write}), 32'd0);
      acked_last = 1'b0;
      if (bus_read || bus_write) begin
        strobe_cycles++;
        checkOutput("rw_exclusive", 32'(bus_read && bus_write), 32'd0);
        if (strobe_cycles == 1) first_addr = bus_address;
        else                    checkOutput("addr_stable", 32'(bus_address), 32'(first_addr));
        if (ack_lat != 0 && strobe_cycles == ack_lat &&
            !(stall_active && bus_read && bus_address == stall_addr)) begin
          bus_ack    = 1'b1;
          acked_last = 1'b1;
          if (bus_read) begin
            bus_read_data = 16'h1000 + bus_address[15:0];
            checkOutput("rd_addr", 32'(bus_address), 32'(exp_rd_addr));
            sample_q.push_back(16'h1000 + exp_rd_addr[15:0]);
            if (exp_rd_addr == TB_PLAY_END) begin
              exp_rd_addr = '0;
              wrap_count++;
            end else begin
              exp_rd_addr = exp_rd_addr + 26'd1;
            end
          end else if (wr_q.size() == 0) begin
            checkOutput("wr_unexpected", 32'd1, 32'd0);
          end else begin
            wr_exp = wr_q.pop_front();
            checkOutput("wr_addr", 32'(bus_address), 32'(wr_exp.addr));
            checkOutput("wr_data", 32'(bus_write_data), 32'(wr_exp.data));
            checkOutput("wr_byte_en", 32'(bus_byte_enable), 32'd3);
          end
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        strobe_cycles = 0;
        bus_ack       = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int write_cycles;
    int read_cycles;
    int acks;
    int last_wr_idx;
    int run;
    int reads_done;
    int wr_seen;
    logic seen;
    logic prev_read;

    Reset         = 1'b1;
    sample_pop    = 1'b0;
    bus_ack       = 1'b0;
    bus_read_data = '0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_bus_read", 32'(bus_read), 32'd0);
    checkOutput("rst_bus_write", 32'(bus_write), 32'd0);
    checkOutput("rst_load_ack", 32'(load_ack), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_sample", 32'(sample_data), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
    checkOutput("rst_addr", 32'(bus_address), 32'd0);
    checkOutput("rst_byte_en", 32'(bus_byte_enable), 32'd0);
    checkOutput("rst_wdata", 32'(bus_write_data), 32'd0);
    Reset = 1'b0;
    tick();
    checkOutput("byte_en_run", 32'(bus_byte_enable), 32'd3);

    // Loader writes: two words back to back, ack after 3 cycles each
    ack_lat = 3;
    wr_q.push_back('{addr: 26'h10, data: 16'hBEEF});
    wr_q.push_back('{addr: 26'h11, data: 16'hCAFE});
    applyStimulus(1'b1, 25'h10, 16'hBEEF, 1'b0, 1'b0);
    write_cycles = 0; read_cycles = 0; acks = 0; last_wr_idx = -10;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_write) begin
        write_cycles++;
        last_wr_idx = i;
      end
      if (bus_read) read_cycles++;
      if (load_ack) begin
        acks++;
        checkOutput("load_ack_timing", 32'(i - last_wr_idx), 32'd1);
        if (acks == 1) begin
          load_addr = 25'h11;
          load_data = 16'hCAFE;
        end else begin
          load_req = 1'b0;
        end
      end
    end
    checkOutput("load_write_cycles", 32'(write_cycles), 32'd6);
    checkOutput("load_ack_pulses", 32'(acks), 32'd2);
    checkOutput("load_no_read", 32'(read_cycles), 32'd0);
    checkOutput("load_all_written", 32'(wr_q.size()), 32'd0);

    // Prefetch fills the FIFO with addresses 0..7, then stops
    ack_lat = 1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    read_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_read) read_cycles++;
    end
    checkOutput("prefetch_reads", 32'(read_cycles), 32'd8);
    checkOutput("prefetch_idle", 32'(bus_read), 32'd0);
    checkOutput("prefetch_valid", 32'(sample_valid), 32'd1);
    checkOutput("prefetch_head", 32'(sample_data), 32'h1000);
    checkOutput("prefetch_sb", 32'(sample_q.size()), 32'd8);
    popSample();
    read_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_read) read_cycles++;
    end
    checkOutput("refill_reads", 32'(read_cycles), 32'd1);
    checkOutput("refill_next_addr", 32'(exp_rd_addr), 32'd9);

    // Continuous popping drives the read address through the wrap point
    for (int i = 0; i < 40; i++) begin
      if (sample_valid) popSample();
      else              tick();
    end
    checkOutput("wrap_seen", 32'(wrap_count >= 1), 32'd1);

    // Pause, drain, then pop an empty FIFO
    play_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sample_valid) popSample();
      else              tick();
    end
    read_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_read) read_cycles++;
    end
    checkOutput("pause_no_read", 32'(read_cycles), 32'd0);
    checkOutput("drained_valid", 32'(sample_valid), 32'd0);
    checkOutput("drained_data", 32'(sample_data), 32'd0);
    checkOutput("drained_sb", 32'(sample_q.size()), 32'd0);
    checkOutput("underrun_pre", 32'(underrun), 32'd0);
    sample_pop = 1'b1;
    tick();
    sample_pop = 1'b0;
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    checkOutput("underrun_valid", 32'(sample_valid), 32'd0);
    tick(); tick(); tick();
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);
    checkOutput("underrun_data", 32'(sample_data), 32'd0);

    // Resume continues from the retained play address
    play_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("resume_valid", 32'(seen), 32'd1);
    if (seen) popSample();
    play_en = 1'b0;
    resetDut();
    checkOutput("rst2_underrun", 32'(underrun), 32'd0);
    checkOutput("rst2_valid", 32'(sample_valid), 32'd0);

    // Timeout: read at address 5 never acked, then retried and acked
    stall_addr   = 26'd5;
    stall_active = 1'b1;
    ack_lat      = 1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    run = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus_read && bus_address == 26'd5) run++;
      if (bus_error) break;
    end
    checkOutput("tmo_error", 32'(bus_error), 32'd1);
    checkOutput("tmo_strobe_cycles", 32'(run), 32'd4);
    checkOutput("tmo_read_dropped", 32'(bus_read), 32'd0);
    checkOutput("tmo_no_push", 32'(sample_q.size()), 32'd5);
    stall_active = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("tmo_refilled", 32'(sample_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) popSample();
    checkOutput("tmo_error_sticky", 32'(bus_error), 32'd1);

    // Priority: loader request during a read waits for the read, then reset mid-write
    play_en = 1'b0;
    resetDut();
    checkOutput("rst3_error", 32'(bus_error), 32'd0);
    ack_lat = 3;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_read) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("prio_read_start", 32'(seen), 32'd1);
    wr_q.push_back('{addr: 26'h20, data: 16'h1234});
    applyStimulus(1'b1, 25'h20, 16'h1234, 1'b0, 1'b1);
    reads_done = 0; wr_seen = 0; prev_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev_read && !bus_read) reads_done++;
      prev_read = bus_read;
      if (bus_write) begin
        wr_seen++;
        if (wr_seen == 1) checkOutput("prio_read_first", 32'(reads_done), 32'd1);
        if (wr_seen == 2) break;
      end
    end
    checkOutput("prio_write_seen", 32'(wr_seen), 32'd2);
    Reset = 1'b1;
    tick();
    checkOutput("rstw_bus_write", 32'(bus_write), 32'd0);
    checkOutput("rstw_load_ack", 32'(load_ack), 32'd0);
    checkOutput("rstw_valid", 32'(sample_valid), 32'd0);
    ack_lat = 1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    Reset = 1'b0;
    acks = 0; read_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (load_ack) acks++;
      if (bus_read) read_cycles++;
    end
    checkOutput("rstw_no_load_ack", 32'(acks), 32'd0);
    checkOutput("rstw_reads_resume", 32'(read_cycles > 0), 32'd1);
    checkOutput("rstw_head_addr0", 32'(sample_data), 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
